id_stage_pipelined: RTL and testbench

Parametrised decode stage for the ARM-subset pipeline. It holds the register file, condition check, control decode, data-hazard stall logic and the registered ID/EX boundary. Instructions arrive from IF over a valid/ready handshake, and decoded bundles leave one cycle later over a second valid/ready handshake to EXE. Write-back enters on a dedicated port with same-cycle bypass.

---
 rtl/id_stage_pipelined.sv | 268 ++++++++++++++++++++++++++
 tb/tb_id_stage_pipelined.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipelined.sv
// id_stage_pipelined: ARM-subset decode stage with register file, condition check, hazard
// stall and a registered ID/EX boundary. Define ID_FORWARD_EN to stall only on load-use hazards.

module id_stage_pipelined #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [3:0]        status,
  input  logic              wb_en,
  input  logic [3:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  input  logic              exe_wb_en,
  input  logic              exe_mem_read,
  input  logic [3:0]        exe_dest,
  input  logic              mem_wb_en,
  input  logic [3:0]        mem_dest,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wb_en,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_branch,
  output logic              out_s,
  output logic              out_imm,
  output logic [3:0]        out_exec_cmd,
  output logic [3:0]        out_dest,
  output logic [3:0]        out_src1,
  output logic [3:0]        out_src2,
  output logic [DATA_W-1:0] out_val_rn,
  output logic [DATA_W-1:0] out_val_rm,
  output logic [DATA_W-1:0] out_pc,
  output logic [11:0]       out_shift_op,
  output logic [23:0]       out_simm24
);

  localparam logic [4:0] NUM_REGS_5 = 5'(NUM_REGS);

  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_TST = 4'b1000;

  localparam logic [1:0] MODE_ALU = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  typedef struct packed {
    logic              wb_en;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              s;
    logic              imm;
    logic [3:0]        exec_cmd;
    logic [3:0]        dest;
    logic [3:0]        src1;
    logic [3:0]        src2;
    logic [DATA_W-1:0] val_rn;
    logic [DATA_W-1:0] val_rm;
    logic [DATA_W-1:0] pc;
    logic [11:0]       shift_op;
    logic [23:0]       simm24;
  } bundle_t;

  function automatic logic in_range(input logic [3:0] idx);
    return ({1'b0, idx} < NUM_REGS_5);
  endfunction

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      4'b0000: return z;
      4'b0001: return !z;
      4'b0010: return c;
      4'b0011: return !c;
      4'b0100: return n;
      4'b0101: return !n;
      4'b0110: return v;
      4'b0111: return !v;
      4'b1000: return c && !z;
      4'b1001: return !c || z;
      4'b1010: return n == v;
      4'b1011: return n != v;
      4'b1100: return !z && (n == v);
      4'b1101: return z || (n != v);
      4'b1110: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] alu_cmd(input logic [3:0] opcode);
    case (opcode)
      4'b1101: return 4'b0001;
      4'b1111: return 4'b1001;
      4'b0100: return 4'b0010;
      4'b0101: return 4'b0011;
      4'b0010: return 4'b0100;
      4'b0110: return 4'b0101;
      4'b0000: return 4'b0110;
      4'b1100: return 4'b0111;
      4'b0001: return 4'b1000;
      4'b1010: return 4'b0100;
      4'b1000: return 4'b0110;
      default: return 4'b0000;
    endcase
  endfunction

  // Same-cycle write-back wins over the stored value so a dependent read sees fresh data.
  function automatic logic [DATA_W-1:0] rf_read(input logic [3:0]        idx,
                                                input logic [DATA_W-1:0] stored,
                                                input logic              byp_en,
                                                input logic [3:0]        byp_dest,
                                                input logic [DATA_W-1:0] byp_val);
    if (!in_range(idx)) return '0;
    if (byp_en && (byp_dest == idx)) return byp_val;
    return stored;
  endfunction

  function automatic bundle_t kill_enables(input bundle_t b);
    bundle_t k;
    k           = b;
    k.wb_en     = 1'b0;
    k.mem_read  = 1'b0;
    k.mem_write = 1'b0;
    k.branch    = 1'b0;
    k.s         = 1'b0;
    return k;
  endfunction

  logic [DATA_W-1:0] rf [16];

  logic [1:0] mode;
  logic [3:0] opcode;
  logic       i_bit;
  logic       s_bit;
  logic [3:0] rn;
  logic [3:0] rd;
  logic [3:0] rm;
  logic       is_store;
  logic [3:0] src2_idx;
  logic       uses_src1;
  logic       uses_src2;
  logic       hit1;
  logic       hit2;
  logic       hazard;
  logic       advance;

  bundle_t dec_p0;
  bundle_t bundle_p1;
  logic    vld_p1;

  assign mode     = in_instr[27:26];
  assign i_bit    = in_instr[25];
  assign opcode   = in_instr[24:21];
  assign s_bit    = in_instr[20];
  assign rn       = in_instr[19:16];
  assign rd       = in_instr[15:12];
  assign rm       = in_instr[3:0];
  assign is_store = (mode == MODE_MEM) && !s_bit;
  assign src2_idx = is_store ? rd : rm;

  assign uses_src1 = !(mode == MODE_BR) &&
                     !((mode == MODE_ALU) && ((opcode == OP_MOV) || (opcode == OP_MVN)));
  assign uses_src2 = ((mode == MODE_ALU) && !i_bit) || is_store;

`ifdef ID_FORWARD_EN
  // EXE forwards ALU results; only a load in EXE has no value to forward yet.
  logic unused_fwd;
  assign unused_fwd = ^{exe_wb_en, mem_wb_en, mem_dest};
  assign hit1 = exe_mem_read && (exe_dest == rn);
  assign hit2 = exe_mem_read && (exe_dest == src2_idx);
`else
  logic unused_fwd;
  assign unused_fwd = exe_mem_read;
  assign hit1 = (exe_wb_en && (exe_dest == rn)) || (mem_wb_en && (mem_dest == rn));
  assign hit2 = (exe_wb_en && (exe_dest == src2_idx)) || (mem_wb_en && (mem_dest == src2_idx));
`endif

  assign hazard   = in_valid && ((uses_src1 && hit1) || (uses_src2 && hit2));
  assign advance  = out_ready || !vld_p1;
  assign in_ready = rst && advance && !hazard && !flush;

  // Stage p0: combinational decode and register read
  always_comb begin
    dec_p0          = '0;
    dec_p0.imm      = i_bit;
    dec_p0.dest     = rd;
    dec_p0.src1     = rn;
    dec_p0.src2     = src2_idx;
    dec_p0.val_rn   = rf_read(rn, rf[rn], wb_en, wb_dest, wb_value);
    dec_p0.val_rm   = rf_read(src2_idx, rf[src2_idx], wb_en, wb_dest, wb_value);
    dec_p0.pc       = in_pc;
    dec_p0.shift_op = in_instr[11:0];
    dec_p0.simm24   = in_instr[23:0];
    case (mode)
      MODE_ALU: begin
        dec_p0.exec_cmd = alu_cmd(opcode);
        dec_p0.wb_en    = (alu_cmd(opcode) != 4'b0000) && (opcode != OP_CMP) && (opcode != OP_TST);
        dec_p0.s        = s_bit;
      end
      MODE_MEM: begin
        dec_p0.exec_cmd  = 4'b0010;
        dec_p0.mem_read  = s_bit;
        dec_p0.wb_en     = s_bit;
        dec_p0.mem_write = !s_bit;
      end
      MODE_BR:  dec_p0.branch = 1'b1;
      default:  ;
    endcase
    if (!cond_pass(in_instr[31:28], status)) begin
      dec_p0          = kill_enables(dec_p0);
      dec_p0.exec_cmd = 4'b0000;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (wb_en && in_range(wb_dest)) begin
      rf[wb_dest] <= wb_value;
    end
  end

  // Stage p1: ID/EX boundary register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1    <= 1'b0;
      bundle_p1 <= '0;
    end else if (flush) begin
      vld_p1    <= 1'b0;
      bundle_p1 <= kill_enables(bundle_p1);
    end else if (advance) begin
      if (in_valid && !hazard) begin
        vld_p1    <= 1'b1;
        bundle_p1 <= dec_p0;
      end else begin
        vld_p1    <= 1'b0;
        bundle_p1 <= kill_enables(bundle_p1);
      end
    end
  end

  assign out_valid     = vld_p1;
  assign out_wb_en     = bundle_p1.wb_en;
  assign out_mem_read  = bundle_p1.mem_read;
  assign out_mem_write = bundle_p1.mem_write;
  assign out_branch    = bundle_p1.branch;
  assign out_s         = bundle_p1.s;
  assign out_imm       = bundle_p1.imm;
  assign out_exec_cmd  = bundle_p1.exec_cmd;
  assign out_dest      = bundle_p1.dest;
  assign out_src1      = bundle_p1.src1;
  assign out_src2      = bundle_p1.src2;
  assign out_val_rn    = bundle_p1.val_rn;
  assign out_val_rm    = bundle_p1.val_rm;
  assign out_pc        = bundle_p1.pc;
  assign out_shift_op  = bundle_p1.shift_op;
  assign out_simm24    = bundle_p1.simm24;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// tb_id_stage_pipelined: directed vectors against a behavioural model of the decode stage,
// plus hand-computed literal expectations.

module tb_id_stage_pipelined;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic [3:0]  status;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;
  logic        exe_wb_en, exe_mem_read;
  logic [3:0]  exe_dest;
  logic        mem_wb_en;
  logic [3:0]  mem_dest;
  logic        flush;
  logic        out_valid, out_ready;
  logic        out_wb_en, out_mem_read, out_mem_write, out_branch, out_s, out_imm;
  logic [3:0]  out_exec_cmd, out_dest, out_src1, out_src2;
  logic [31:0] out_val_rn, out_val_rm, out_pc;
  logic [11:0] out_shift_op;
  logic [23:0] out_simm24;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_stage_pipelined #(.DATA_W(32), .NUM_REGS(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .status(status),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read), .exe_dest(exe_dest),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wb_en(out_wb_en), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_branch(out_branch), .out_s(out_s), .out_imm(out_imm),
    .out_exec_cmd(out_exec_cmd), .out_dest(out_dest), .out_src1(out_src1), .out_src2(out_src2),
    .out_val_rn(out_val_rn), .out_val_rm(out_val_rm), .out_pc(out_pc),
    .out_shift_op(out_shift_op), .out_simm24(out_simm24)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        wb, mr, mw, br, s, imm;
    logic [3:0]  cmd, dest, src1, src2;
    logic [31:0] rn, rm, pc;
    logic [11:0] sh;
    logic [23:0] simm;
  } exp_t;

  exp_t        e;
  logic        e_valid;
  logic [31:0] m_rf [16];
  logic [3:0]  cmd_tab [16];

  initial begin
    for (int i = 0; i < 16; i++) cmd_tab[i] = 4'h0;
    cmd_tab[13] = 4'h1; cmd_tab[15] = 4'h9; cmd_tab[4]  = 4'h2; cmd_tab[5]  = 4'h3;
    cmd_tab[2]  = 4'h4; cmd_tab[6]  = 4'h5; cmd_tab[0]  = 4'h6; cmd_tab[12] = 4'h7;
    cmd_tab[1]  = 4'h8; cmd_tab[10] = 4'h4; cmd_tab[8]  = 4'h6;
  end

  // ARM pairs conditions: odd codes are the negation of the preceding even code.
  function automatic logic m_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] r);
    if (wb_en && wb_dest == r) return wb_value;
    return m_rf[r];
  endfunction

  function automatic exp_t m_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t       r;
    logic [1:0] mode;
    logic [3:0] op;
    logic       sb;
    mode   = ins[27:26];
    op     = ins[24:21];
    sb     = ins[20];
    r      = '0;
    r.imm  = ins[25];
    r.dest = ins[15:12];
    r.src1 = ins[19:16];
    r.src2 = (mode == 2'b01 && !sb) ? ins[15:12] : ins[3:0];
    r.rn   = m_read(r.src1);
    r.rm   = m_read(r.src2);
    r.pc   = pc;
    r.sh   = ins[11:0];
    r.simm = ins[23:0];
    if (m_cond(ins[31:28], status)) begin
      if (mode == 2'b00) begin
        r.cmd = cmd_tab[op];
        r.wb  = (r.cmd != 4'h0) && (op != 4'b1010) && (op != 4'b1000);
        r.s   = sb;
      end else if (mode == 2'b01) begin
        r.cmd = 4'h2;
        r.mr  = sb;
        r.wb  = sb;
        r.mw  = !sb;
      end else if (mode == 2'b10) begin
        r.br = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic m_hazard();
    logic [15:0] busy, needs;
    logic [1:0]  mode;
    logic [3:0]  op, s2;
    mode = in_instr[27:26];
    op   = in_instr[24:21];
    s2   = (mode == 2'b01 && !in_instr[20]) ? in_instr[15:12] : in_instr[3:0];
`ifdef ID_FORWARD_EN
    busy = exe_mem_read ? (16'd1 << exe_dest) : 16'd0;
`else
    busy = (exe_wb_en ? (16'd1 << exe_dest) : 16'd0) | (mem_wb_en ? (16'd1 << mem_dest) : 16'd0);
`endif
    needs = 16'd0;
    if (mode != 2'b10 && !(mode == 2'b00 && (op == 4'd13 || op == 4'd15)))
      needs |= 16'd1 << in_instr[19:16];
    if ((mode == 2'b00 && !in_instr[25]) || (mode == 2'b01 && !in_instr[20]))
      needs |= 16'd1 << s2;
    return in_valid && ((busy & needs) != 16'd0);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_valid <= 1'b0;
      e       <= '0;
      for (int i = 0; i < 16; i++) m_rf[i] <= 32'h0;
    end else begin
      if (flush || !(out_ready || !e_valid) ) begin
        if (flush) begin
          e_valid <= 1'b0;
          e.wb <= 1'b0; e.mr <= 1'b0; e.mw <= 1'b0; e.br <= 1'b0; e.s <= 1'b0;
        end
      end else if (in_valid && !m_hazard()) begin
        e_valid <= 1'b1;
        e       <= m_decode(in_instr, in_pc);
      end else begin
        e_valid <= 1'b0;
        e.wb <= 1'b0; e.mr <= 1'b0; e.mw <= 1'b0; e.br <= 1'b0; e.s <= 1'b0;
      end
      if (wb_en) m_rf[wb_dest] <= wb_value;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    chk("out_valid", out_valid, e_valid);
    chk("in_ready", in_ready, rst && (out_ready || !e_valid) && !m_hazard() && !flush);
    chk("wb_en", out_wb_en, e.wb);
    chk("mem_read", out_mem_read, e.mr);
    chk("mem_write", out_mem_write, e.mw);
    chk("branch", out_branch, e.br);
    chk("s", out_s, e.s);
    if (e_valid || !rst) begin
      chk("imm", out_imm, e.imm);
      chk("exec_cmd", out_exec_cmd, e.cmd);
      chk("dest", out_dest, e.dest);
      chk("src1", out_src1, e.src1);
      chk("src2", out_src2, e.src2);
      chk("val_rn", out_val_rn, e.rn);
      chk("val_rm", out_val_rm, e.rm);
      chk("pc", out_pc, e.pc);
      chk("shift_op", out_shift_op, e.sh);
      chk("simm24", out_simm24, e.simm);
    end
  end

  // ---------------- directed stimulus ----------------
  typedef struct {
    logic [31:0] ins;
    logic [3:0]  st;
    logic        wb, mr, mw, br;
    logic [3:0]  cmd;
    logic [3:0]  src2;
  } vec_t;

  vec_t tab [12];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    tab[0]  = '{32'hE5916000, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h2, 4'h0};
    tab[1]  = '{32'hE5816000, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h2, 4'h6};
    tab[2]  = '{32'hE1520003, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h4, 4'h3};
    tab[3]  = '{32'hE3E07000, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h9, 4'h0};
    tab[4]  = '{32'hE0212003, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h8, 4'h3};
    tab[5]  = '{32'hE0623002, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h2};
    tab[6]  = '{32'h10823002, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h2};
    tab[7]  = '{32'hA0823002, 4'hD, 1'b1, 1'b0, 1'b0, 1'b0, 4'h2, 4'h2};
    tab[8]  = '{32'h80823002, 4'hD, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h2};
    tab[9]  = '{32'hF0823002, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h2};
    tab[10] = '{32'hEF000000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0};
    tab[11] = '{32'hEA000010, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0};

    in_valid = 0; in_instr = 0; in_pc = 0; status = 0;
    wb_en = 0; wb_dest = 0; wb_value = 0;
    exe_wb_en = 0; exe_mem_read = 0; exe_dest = 0;
    mem_wb_en = 0; mem_dest = 0; flush = 0; out_ready = 1;

    #1 rst = 0;
    #2;
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 0);
    chk("rst out_pc", out_pc, 0);
    step(); step();
    rst = 1;
    #1 chk("release in_ready", in_ready, 1);

    // MOV R1,#5
    in_valid = 1; in_instr = 32'hE3A01005; in_pc = 32'h100;
    step();
    in_valid = 0;
    chk("mov valid", out_valid, 1);
    chk("mov cmd", out_exec_cmd, 4'b0001);
    chk("mov wb", out_wb_en, 1);
    chk("mov imm", out_imm, 1);
    chk("mov dest", out_dest, 1);
    chk("mov shift", out_shift_op, 12'h005);

    // ADD R3,R2,R2 with same-cycle write-back of R2
    wb_en = 1; wb_dest = 2; wb_value = 32'hAA;
    in_valid = 1; in_instr = 32'hE0823002; in_pc = 32'h104;
    step();
    wb_en = 0; in_valid = 0;
    chk("byp val_rn", out_val_rn, 32'hAA);
    chk("byp val_rm", out_val_rm, 32'hAA);
    chk("byp cmd", out_exec_cmd, 4'b0010);

    // EXE producer hazard on R2
    exe_wb_en = 1; exe_dest = 2; in_valid = 1; in_instr = 32'hE0823002; in_pc = 32'h108;
    #1;
`ifdef ID_FORWARD_EN
    chk("exe haz in_ready", in_ready, 1);
    step();
    chk("exe haz out_valid", out_valid, 1);
`else
    chk("exe haz in_ready", in_ready, 0);
    step();
    chk("exe haz bubble", out_valid, 0);
`endif
    exe_mem_read = 1;
    #1 chk("load-use in_ready", in_ready, 0);
    step();
    chk("load-use bubble", out_valid, 0);
    exe_wb_en = 0; exe_mem_read = 0; mem_wb_en = 1; mem_dest = 2;
    step();
    mem_wb_en = 0;
    step();
    in_valid = 0;
    chk("post-stall valid", out_valid, 1);
    chk("post-stall val_rn", out_val_rn, 32'hAA);

    // BEQ with Z clear, then set
    status = 4'b0000; in_valid = 1; in_instr = 32'h0A000004; in_pc = 32'h200;
    step();
    chk("beq nz valid", out_valid, 1);
    chk("beq nz branch", out_branch, 0);
    chk("beq nz cmd", out_exec_cmd, 4'b0000);
    status = 4'b0100;
    step();
    in_valid = 0;
    chk("beq z branch", out_branch, 1);
    chk("beq z simm", out_simm24, 24'h000004);

    // mixed instruction table
    for (int i = 0; i < 12; i++) begin
      in_valid = 1; in_instr = tab[i].ins; status = tab[i].st; in_pc = 32'h300 + 32'(i * 4);
      wb_en = (i == 3); wb_dest = 3; wb_value = 32'h12345678;
      step();
      chk("tab wb", out_wb_en, tab[i].wb);
      chk("tab mem_read", out_mem_read, tab[i].mr);
      chk("tab mem_write", out_mem_write, tab[i].mw);
      chk("tab branch", out_branch, tab[i].br);
      chk("tab cmd", out_exec_cmd, tab[i].cmd);
      chk("tab src2", out_src2, tab[i].src2);
    end
    wb_en = 0; in_valid = 0; status = 0;

    // back-pressure hold with flush in the second cycle
    in_valid = 1; in_instr = 32'hE3A04007; in_pc = 32'h400;
    step();
    chk("hold load dest", out_dest, 4);
    out_ready = 0; in_instr = 32'hE3A05009; in_pc = 32'h404;
    #1 chk("hold in_ready c1", in_ready, 0);
    step();
    chk("hold valid c1", out_valid, 1);
    chk("hold dest c1", out_dest, 4);
    flush = 1;
    #1 chk("flush in_ready", in_ready, 0);
    step();
    chk("flush kills", out_valid, 0);
    flush = 0;
    step();
    chk("after flush valid", out_valid, 1);
    chk("after flush dest", out_dest, 5);

    // reset while stalled behind a hazard
    in_instr = 32'hE0823002; in_pc = 32'h500; exe_wb_en = 1; exe_dest = 2;
    step();
    #1 rst = 0;
    #1;
    chk("async rst valid", out_valid, 0);
    chk("async rst dest", out_dest, 0);
    chk("async rst pc", out_pc, 0);
    chk("async rst in_ready", in_ready, 0);
    in_valid = 0; exe_wb_en = 0; out_ready = 1;
    step();
    rst = 1;
    #1 chk("rerelease in_ready", in_ready, 1);
    step();
    chk("stalled discarded", out_valid, 0);
    in_valid = 1;
    step();
    in_valid = 0;
    chk("first after rst valid", out_valid, 1);
    chk("first after rst val_rn", out_val_rn, 0);
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
